// File: rtl/data_merge_pkg.sv
// Shared widths and FSM encodings for reassembling chunked words into one wide word.
// Chunk width matches the output bus; the merged word matches the multiplier result.
package data_merge_pkg;

  localparam int CHUNK_W = 16;
  localparam int WORD_W  = 2 * CHUNK_W;

  // 2'd3 is not a legal state; the FSM steers it back to WAIT_LO.
  typedef enum logic [1:0] {
    WAIT_LO = 2'd0,
    WAIT_HI = 2'd1,
    FULL    = 2'd2
  } state_e;

endpackage

// File: rtl/data_merge.sv
// Pairs two sequential chunks (low first) into {high, low}; word valid the edge after the high chunk.
// Holds one word until taken; while full, a chunk is accepted only alongside the output transfer.
module data_merge #(
  parameter int CHUNK_W = data_merge_pkg::CHUNK_W
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [CHUNK_W-1:0]     data_in_i,
  output logic                   chunk_count_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [2*CHUNK_W-1:0]   data_out_o
);
  import data_merge_pkg::*;

  localparam int WORD_W = 2 * CHUNK_W;

  state_e              state_q, state_d;
  logic [CHUNK_W-1:0]  low_q, low_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                in_xfer;
  logic                out_xfer;

  // Ready depends only on state, out_ready_i and reset, never on in_valid_i.
  always_comb begin
    in_ready_o = 1'b0;
    case (state_q)
      WAIT_LO, WAIT_HI: in_ready_o = 1'b1;
      FULL:             in_ready_o = out_ready_i;
      default:          in_ready_o = 1'b0;
    endcase
    if (rst_i) begin
      in_ready_o = 1'b0;
    end
  end

  assign out_valid_o   = (state_q == FULL);
  assign chunk_count_o = (state_q == WAIT_HI);
  assign data_out_o    = data_q;

  assign in_xfer  = in_valid_i & in_ready_o;
  assign out_xfer = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    low_d   = low_q;
    data_d  = data_q;
    if (clear_i) begin
      // Drop partial and held words; data_q is left as-is since it is don't-care when not valid.
      state_d = WAIT_LO;
      low_d   = '0;
    end else begin
      case (state_q)
        WAIT_LO: begin
          if (in_xfer) begin
            low_d   = data_in_i;
            state_d = WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (in_xfer) begin
            data_d  = {data_in_i, low_q};
            state_d = FULL;
          end
        end
        FULL: begin
          if (out_xfer) begin
            if (in_xfer) begin
              low_d   = data_in_i;
              state_d = WAIT_HI;
            end else begin
              state_d = WAIT_LO;
            end
          end
        end
        default: state_d = WAIT_LO;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= WAIT_LO;
      low_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      low_q   <= low_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_data_merge.sv
// Directed and random stimulus for data_merge, checked against a chunk-pairing queue model.
module tb_data_merge;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] data_in;
  logic        chunk_count;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;

  int checks = 0;
  int errors = 0;

  data_merge #(.CHUNK_W(16)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .clear_i       (clear),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .data_in_i     (data_in),
    .chunk_count_o (chunk_count),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .data_out_o    (data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Model: accepted chunks pair up low-then-high; completed words wait in a queue of depth one.
  logic [31:0] exp_q[$];
  logic        have_low = 1'b0;
  logic [15:0] low_val  = '0;
  logic        model_en = 1'b0;
  int          n_acc    = 0;
  int          n_taken  = 0;

  always @(negedge clk) begin
    logic exp_rdy;
    if (model_en) begin
      exp_rdy = rst ? 1'b0 : ((exp_q.size() == 0) ? 1'b1 : out_ready);
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
      if (out_valid && exp_q.size() != 0) chk("data_out", data_out, exp_q[0]);
      chk("chunk_count", {31'd0, chunk_count}, {31'd0, have_low});
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      if (rst || clear) begin
        exp_q.delete();
        have_low = 1'b0;
      end else begin
        if (exp_q.size() != 0 && out_ready) begin
          void'(exp_q.pop_front());
          n_taken++;
        end
        if (in_valid && exp_rdy) begin
          n_acc++;
          if (have_low) begin
            exp_q.push_back({data_in, low_val});
            have_low = 1'b0;
          end else begin
            low_val  = data_in;
            have_low = 1'b1;
          end
        end
      end
    end
  end

  logic [31:0] stream_w [3];
  int          acc0, taken0, budget;

  initial begin
    stream_w = '{32'h0002_0001, 32'h0004_0003, 32'h0006_0005};
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; data_in = '0;

    // Reset
    cyc();
    model_en = 1'b1;
    cyc();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_chunk_count", {31'd0, chunk_count}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;

    // Basic word
    out_ready = 1'b1;
    in_valid = 1'b1; data_in = 16'h1234;
    #1 chk("basic_cc0", {31'd0, chunk_count}, 32'd0);
    cyc();
    chk("basic_cc1", {31'd0, chunk_count}, 32'd1);
    data_in = 16'hABCD;
    cyc();
    in_valid = 1'b0;
    chk("basic_valid", {31'd0, out_valid}, 32'd1);
    chk("basic_word", data_out, 32'hABCD_1234);
    chk("basic_cc2", {31'd0, chunk_count}, 32'd0);
    cyc();
    chk("basic_one_cycle", {31'd0, out_valid}, 32'd0);

    // Backpressure
    out_ready = 1'b0;
    in_valid = 1'b1; data_in = 16'hFF00;
    cyc();
    data_in = 16'h00FF;
    cyc();
    data_in = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold", data_out, 32'h00FF_FF00);
      cyc();
    end
    out_ready = 1'b1;
    #1 chk("bp_release_rdy", {31'd0, in_ready}, 32'd1);
    cyc();
    chk("bp_low_taken_cc", {31'd0, chunk_count}, 32'd1);
    chk("bp_word_gone", {31'd0, out_valid}, 32'd0);
    data_in = 16'h6666;
    cyc();
    in_valid = 1'b0;
    chk("bp_next_word", data_out, 32'h6666_5555);
    cyc();

    // Streaming
    in_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      data_in = 16'(i);
      cyc();
      if (i % 2 == 0) begin
        chk("stream_valid", {31'd0, out_valid}, 32'd1);
        chk("stream_word", data_out, stream_w[i/2 - 1]);
      end else if (i > 1) begin
        chk("stream_gap", {31'd0, out_valid}, 32'd0);
      end
    end
    in_valid = 1'b0;
    cyc();

    // Clear mid-word, with a chunk offered during the clear cycle
    in_valid = 1'b1; data_in = 16'hAAAA;
    cyc();
    clear = 1'b1; data_in = 16'hBBBB;
    cyc();
    clear = 1'b0;
    chk("clr_cc", {31'd0, chunk_count}, 32'd0);
    data_in = 16'h1111;
    cyc();
    data_in = 16'h2222;
    cyc();
    in_valid = 1'b0;
    chk("clr_word", data_out, 32'h2222_1111);
    cyc();

    // Reset with a word held
    out_ready = 1'b0;
    in_valid = 1'b1; data_in = 16'h0003;
    cyc();
    data_in = 16'h0004;
    cyc();
    in_valid = 1'b0;
    chk("rm_held", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1 chk("rm_rdy_now", {31'd0, in_ready}, 32'd0);
    cyc();
    chk("rm_valid", {31'd0, out_valid}, 32'd0);
    chk("rm_data", data_out, 32'd0);
    chk("rm_cc", {31'd0, chunk_count}, 32'd0);
    chk("rm_rdy", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;

    // Randomised traffic
    acc0 = n_acc; taken0 = n_taken; budget = 0;
    while ((n_acc - acc0) < 10000 && budget < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      data_in   = 16'($urandom);
      cyc();
      budget++;
    end
    if (budget >= 60000) chk("rand_budget", 32'(n_acc - acc0), 32'd10000);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cyc();
    chk("rand_words", 32'(n_taken - taken0), 32'((n_acc - acc0) / 2));
    chk("rand_parity", {31'd0, chunk_count}, 32'((n_acc - acc0) % 2));
    chk("rand_drained", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_merge.md
Name: data_merge

Overview:
- Inverse of the accelerator's multiply-result splitter: collects two sequential output-width chunks (low first, then high) and reassembles one double-width word.
- Sits on the return path from narrow output buses, e.g. a readback from an output FIFO, feeding wide multiply-width consumers.
- Valid/ready handshake on both sides; holds one assembled word until it is taken.

Parameters:
- CHUNK_W, 16, width of one chunk; equals `outputIndex+1.
- WORD_W, 2*CHUNK_W, merged word width; equals `multiplyIndex+1; not independently overridable.

Ports:
- Clk  in  1  single clock, rising edge.
- Rst  in  1  synchronous, active-high reset.
- Clear  in  1  synchronous discard of any partial or held word.
- inValid  in  1  chunk present on dataIn.
- inReady  out  1  block accepts dataIn this cycle.
- dataIn  in  CHUNK_W  chunk; low half first, then high half.
- chunkCount  out  1  next chunk expected: 0 = low, 1 = high; same encoding as the splitter's select.
- outValid  out  1  dataOut holds a complete word.
- outReady  in  1  consumer takes dataOut.
- dataOut  out  WORD_W  {high chunk, low chunk}.

Behaviour:
- Reset: Rst is sampled on the Clk edge and overrides everything.
  - State becomes WAIT_LO.
  - outValid=0, dataOut=0, chunkCount=0, low-chunk holding register=0.
  - inReady is forced to 0 while Rst=1.
- Input transfer: inValid & inReady on a rising edge. Output transfer: outValid & outReady on a rising edge.
- State WAIT_LO (chunkCount=0, inReady=1, outValid=0): on an input transfer, capture dataIn into the low register and go to WAIT_HI.
- State WAIT_HI (chunkCount=1, inReady=1, outValid=0): on an input transfer, dataOut <= {dataIn, lowReg} and go to FULL.
- State FULL (outValid=1, inReady=outReady, chunkCount=0):
  - Output transfer with no input transfer: go to WAIT_LO.
  - Output transfer with a simultaneous input transfer: the incoming chunk is the next word's low chunk; capture it and go to WAIT_HI.
  - No output transfer: hold dataOut stable and accept nothing.
- Latency: outValid rises on the edge after the edge that accepted the high chunk.
- Throughput: one word per 2 cycles with continuous inValid=1 and outReady=1.
- Output stability: dataOut and outValid are registered and do not change while outValid=1 and outReady=0.
- Ready paths: inReady depends only on state, outReady and Rst; no combinational path from inValid to inReady.
- Clear: acts next edge, lower priority than Rst, higher than all transfers.
  - State goes to WAIT_LO, outValid=0, and the low register and any held word are discarded.
  - dataOut keeps its old value but is don't-care while outValid=0.
  - A chunk presented in the same cycle as Clear is dropped, even though inReady may read 1.
- Reset mid-word: a low chunk already accepted is lost; the next chunk after reset is treated as a low chunk.
- No arithmetic is performed: pure concatenation, no sign extension, bit-exact.

Decomposition:
- Shared header: CHUNK_W and WORD_W derive from the existing `outputIndex and `multiplyIndex defines in definitions.h.
- Add three state encodings to the same header: WAIT_LO=2'd0, WAIT_HI=2'd1, FULL=2'd2. 2'd3 is illegal and recovers to WAIT_LO.
- No sub-module; a single always block for the FSM plus registers is sufficient.

Test Plan:
- Basic word: reset for 2 cycles, outReady=1, send 0x1234 then 0xABCD -> dataOut=0xABCD1234 with outValid=1 for exactly 1 cycle; chunkCount sequence 0,1,0.
- Backpressure: outReady=0 after the word 0x00FF_FF00 completes, inValid held at 1 with 0x5555 -> inReady=0 and dataOut stable for 5 cycles. Then raise outReady=1 -> word taken, 0x5555 captured as low in the same cycle, chunkCount=1.
- Streaming: inValid=1 and outReady=1 continuously with chunks 1,2,3,4,5,6 -> words 0x00020001, 0x00040003, 0x00060005 on every second cycle.
- Clear mid-word: send 0xAAAA, assert Clear for 1 cycle, then send 0x1111 and 0x2222 -> dataOut=0x22221111; 0xAAAA is never observed.
- Reset mid-operation: assert Rst with a word held (outValid=1) -> next cycle outValid=0, dataOut=0, chunkCount=0, and inReady=0 while Rst=1.
- Randomised: random inValid/outReady, compare against a reference queue pairing chunks -> no loss, duplication or reordering over 10,000 chunks.
